// File: rtl/cdb_writeback_arbiter.sv
// cdb_writeback_arbiter: per-FU one-entry result buffers sharing a single registered CDB.
// Round-robin by default; define CDB_OLDEST_FIRST_EN for oldest-ROB-entry-first arbitration.
module cdb_writeback_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int PHY_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [ROB_WIDTH-1:0]           rob_head,
  input  logic [NUM_FU-1:0]              fu_valid,
  output logic [NUM_FU-1:0]              fu_ready,
  input  logic [NUM_FU*PHY_WIDTH-1:0]    fu_prd,
  input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_data,
  input  logic [NUM_FU*ROB_WIDTH-1:0]    fu_rob_idx,
  output logic                           cdb_valid,
  output logic [PHY_WIDTH-1:0]           cdb_prd,
  output logic [DATA_WIDTH-1:0]          cdb_data,
  output logic [ROB_WIDTH-1:0]           cdb_rob_idx,
  output logic [$clog2(NUM_FU)-1:0]      cdb_fu_id
);

  localparam int FU_ID_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]     buf_v;
  logic [PHY_WIDTH-1:0]  buf_prd  [NUM_FU];
  logic [DATA_WIDTH-1:0] buf_data [NUM_FU];
  logic [ROB_WIDTH-1:0]  buf_rob  [NUM_FU];

  logic                  grant_any;
  logic [FU_ID_W-1:0]    grant_id;
  logic [NUM_FU-1:0]     grant;

`ifdef CDB_OLDEST_FIRST_EN
  logic [ROB_WIDTH-1:0]  age;
  logic [ROB_WIDTH-1:0]  best_age;

  // Age is the wrap-around distance from the ROB head; strict < keeps the lower FU on a tie.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    age       = '0;
    best_age  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      age = buf_rob[i] - rob_head;
      if (buf_v[i] && (!grant_any || (age < best_age))) begin
        grant_any = 1'b1;
        grant_id  = FU_ID_W'(i);
        best_age  = age;
      end
    end
  end
`else
  logic [FU_ID_W-1:0]    rr_ptr;
  logic                  unused_rob_head;

  assign unused_rob_head = ^rob_head;

  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!grant_any && buf_v[idx]) begin
        grant_any = 1'b1;
        grant_id  = FU_ID_W'(idx);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_id] = 1'b1;
  end

  // A granted buffer drains this cycle, so it may be refilled at the same edge.
  assign fu_ready = flush ? '0 : (~buf_v | grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v       <= '0;
      cdb_valid   <= 1'b0;
      cdb_prd     <= '0;
      cdb_data    <= '0;
      cdb_rob_idx <= '0;
      cdb_fu_id   <= '0;
`ifndef CDB_OLDEST_FIRST_EN
      rr_ptr      <= '0;
`endif
    end else if (flush) begin
      buf_v     <= '0;
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_prd     <= buf_prd[grant_id];
        cdb_data    <= buf_data[grant_id];
        cdb_rob_idx <= buf_rob[grant_id];
        cdb_fu_id   <= grant_id;
`ifndef CDB_OLDEST_FIRST_EN
        rr_ptr      <= (grant_id == FU_ID_W'(NUM_FU - 1)) ? '0 : grant_id + FU_ID_W'(1);
`endif
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          buf_v[i]    <= 1'b1;
          buf_prd[i]  <= fu_prd[i*PHY_WIDTH +: PHY_WIDTH];
          buf_data[i] <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
          buf_rob[i]  <= fu_rob_idx[i*ROB_WIDTH +: ROB_WIDTH];
        end else if (grant[i]) begin
          buf_v[i] <= 1'b0;
        end
      end
    end
  end

endmodule
